// File: rtl/stream_pixel_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_pixel_packer_if
// Description : Pixel input handshake plus 32-bit AXI4-Stream style output.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_pixel_packer_if;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        out_stream_tuser;
  logic        out_stream_tlast;

  // master: the packer itself (accepts pixels, sources the word stream)
  modport master (
    input  in_r, in_g, in_b, in_valid, out_stream_tready,
    output in_ready, out_stream_tdata, out_stream_tkeep,
    output out_stream_tvalid, out_stream_tuser, out_stream_tlast
  );

  // slave: the environment (pixel source and word sink)
  modport slave (
    output in_r, in_g, in_b, in_valid, out_stream_tready,
    input  in_ready, out_stream_tdata, out_stream_tkeep,
    input  out_stream_tvalid, out_stream_tuser, out_stream_tlast
  );
endinterface
`default_nettype wire

// File: rtl/stream_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_pixel_packer
// Description : Packs 24-bit RGB pixels into 32-bit words (4 pixels -> 3
//               words) with SOF on tuser and EOL on tlast.
//               Optional macro PACKER_FRAME_COUNT_EN enables frame_count.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pixel_packer #(
  parameter int X_PIXELS = 640,
  parameter int Y_LINES  = 480
) (
  input  logic                  out_stream_aclk,
  input  logic                  axi_resetn,
  stream_pixel_packer_if.master bus,
  output logic [15:0]           frame_count
);

  localparam int X_WORDS = X_PIXELS * 3 / 4;
  localparam int c_XW    = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
  localparam int c_YW    = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;
  localparam logic [c_XW-1:0] c_X_LAST = c_XW'(X_WORDS - 1);
  localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(Y_LINES - 1);

  localparam logic [1:0] c_PIX0 = 2'd0;
  localparam logic [1:0] c_PIX1 = 2'd1;
  localparam logic [1:0] c_PIX2 = 2'd2;
  localparam logic [1:0] c_PIX3 = 2'd3;

  logic [1:0]      r_phase;
  logic [1:0]      w_phase_nxt;
  logic [23:0]     r_hold;
  logic [31:0]     r_tdata;
  logic            r_tvalid;
  logic            r_tuser;
  logic            r_tlast;
  logic [c_XW-1:0] r_x;
  logic [c_YW-1:0] r_y;
  logic [c_XW-1:0] w_x_nxt;
  logic [c_YW-1:0] w_y_nxt;
  logic [23:0]     w_pix;
  logic [31:0]     w_word;
  logic            w_can_load;
  logic            w_accept;
  logic            w_load;
  logic            w_xfer;

  assign w_pix      = {bus.in_r, bus.in_g, bus.in_b};
  assign w_can_load = !r_tvalid || bus.out_stream_tready;
  assign w_xfer     = r_tvalid && bus.out_stream_tready;
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_load     = w_accept && (r_phase != c_PIX0);

  // PIX0 only fills the hold register, so it never waits on the output side
  assign bus.in_ready = axi_resetn && ((r_phase == c_PIX0) || w_can_load);

  assign bus.out_stream_tdata  = r_tdata;
  assign bus.out_stream_tvalid = r_tvalid;
  assign bus.out_stream_tuser  = r_tuser;
  assign bus.out_stream_tlast  = r_tlast;
  assign bus.out_stream_tkeep  = 4'hF;

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_accept) begin
      case (r_phase)
        c_PIX0:  w_phase_nxt = c_PIX1;
        c_PIX1:  w_phase_nxt = c_PIX2;
        c_PIX2:  w_phase_nxt = c_PIX3;
        default: w_phase_nxt = c_PIX0;
      endcase
    end
  end

  always_comb begin
    w_word = 32'd0;
    case (r_phase)
      c_PIX1:  w_word = {w_pix[7:0],  r_hold};
      c_PIX2:  w_word = {w_pix[15:0], r_hold[23:8]};
      c_PIX3:  w_word = {w_pix,       r_hold[23:16]};
      default: w_word = 32'd0;
    endcase
  end

  // Counters track transferred words; their post-transfer value is the
  // position of any word loaded on the same edge.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_xfer) begin
      if (r_x == c_X_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!axi_resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!axi_resetn) begin
      r_phase  <= c_PIX0;
      r_hold   <= 24'd0;
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_accept) begin
        r_hold <= w_pix;
      end
      if (w_load) begin
        r_tdata  <= w_word;
        r_tvalid <= 1'b1;
        r_tuser  <= (w_x_nxt == '0) && (w_y_nxt == '0);
        r_tlast  <= (w_x_nxt == c_X_LAST);
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
      end
    end
  end

`ifdef PACKER_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge out_stream_aclk) begin
    if (!axi_resetn) begin
      r_frame_count <= 16'd0;
    end else if (w_xfer && (r_x == c_X_LAST) && (r_y == c_Y_LAST)) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pixel_packer
// Description : Randomized bench for stream_pixel_packer with a byte-queue
//               reference model. Honours PACKER_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pixel_packer;
  localparam int XP = 16;
  localparam int YL = 4;
  localparam int XW = XP * 3 / 4;
  localparam int FW = XW * YL;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] frame_count;
  logic        fix_ready;
  logic        rnd_ready;
  logic        rnd_bit;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_xfer = 0;
  int k = 0;

  logic [7:0]  byte_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] seen[$];
  logic        prev_stall;
  logic [34:0] prev_out;
  logic [31:0] mw;
  logic [33:0] me;

  always #5 clk = ~clk;

  stream_pixel_packer_if bus();

  assign bus.out_stream_tready = rnd_ready ? rnd_bit : fix_ready;

  stream_pixel_packer #(.X_PIXELS(XP), .Y_LINES(YL)) dut (
    .out_stream_aclk (clk),
    .axi_resetn      (resetn),
    .bus             (bus),
    .frame_count     (frame_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] p);
    logic acc;
    acc = 1'b0;
    {bus.in_r, bus.in_g, bus.in_b} = p;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_stream(input int n);
    logic [31:0] rv;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
      rv = $urandom;
      send_pixel(rv[23:0]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.out_stream_tvalid;
    end
    if (!done) chk("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 1) == 1);
    end
  end

  // Reference model: pixels become a little-endian byte stream, every four
  // bytes form one word, SOF/EOL follow from the word index alone.
  always @(negedge clk) begin
    if (!resetn) begin
      byte_q.delete();
      exp_q.delete();
      seen.delete();
      k = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {bus.out_stream_tvalid, bus.out_stream_tuser,
                           bus.out_stream_tlast, bus.out_stream_tdata}, prev_out);
      prev_stall = bus.out_stream_tvalid && !bus.out_stream_tready;
      prev_out   = {bus.out_stream_tvalid, bus.out_stream_tuser,
                    bus.out_stream_tlast, bus.out_stream_tdata};
      if (bus.out_stream_tvalid && bus.out_stream_tready) begin
        n_xfer++;
        seen.push_back({bus.out_stream_tuser, bus.out_stream_tlast, bus.out_stream_tdata});
        chk("tkeep", bus.out_stream_tkeep, 4'hF);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          me = exp_q.pop_front();
          chk("word", {bus.out_stream_tuser, bus.out_stream_tlast, bus.out_stream_tdata}, me);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        byte_q.push_back(bus.in_b);
        byte_q.push_back(bus.in_g);
        byte_q.push_back(bus.in_r);
        while (byte_q.size() >= 4) begin
          mw = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
          repeat (4) void'(byte_q.pop_front());
          exp_q.push_back({(k % FW) == 0, (k % XW) == XW - 1, mw});
          k++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int x0;
    int fc_exp;
    logic acc;
    logic [31:0] rv;

    resetn = 1'b0;
    fix_ready = 1'b1;
    rnd_ready = 1'b0;
    bus.in_valid = 1'b1;
    {bus.in_r, bus.in_g, bus.in_b} = 24'h010203;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", bus.out_stream_tvalid, 0);
    chk("rst_tdata", bus.out_stream_tdata, 0);
    chk("rst_tuser", bus.out_stream_tuser, 0);
    chk("rst_tlast", bus.out_stream_tlast, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_frame_count", frame_count, 0);
    tick();
    resetn = 1'b1;
    bus.in_valid = 1'b0;

    send_pixel(24'h112233);
    send_pixel(24'h445566);
    send_pixel(24'h778899);
    send_pixel(24'hAABBCC);

    // last word stays pending; exactly one more pixel fits (PIX0)
    fix_ready = 1'b0;
    a0 = n_acc;
    rv = $urandom;
    {bus.in_r, bus.in_g, bus.in_b} = rv[23:0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) begin
        rv = $urandom;
        {bus.in_r, bus.in_g, bus.in_b} = rv[23:0];
      end
    end
    @(negedge clk);
    chk("bp_accepts", n_acc - a0, 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_tvalid", bus.out_stream_tvalid, 1);
    tick();
    bus.in_valid = 1'b0;
    fix_ready = 1'b1;
    drain();
    chk("w0", seen[0], {1'b1, 1'b0, 32'h66112233});
    chk("w1", seen[1], {1'b0, 1'b0, 32'h88994455});
    chk("w2", seen[2], {1'b0, 1'b0, 32'hAABBCC77});

    rnd_ready = 1'b1;
    send_stream(2 * XP * YL + 5);
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    drain();

    // reset two pixels into line 2 with the first word of that line pending
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rnd_ready = 1'b1;
    send_stream(2 * XP + 2);
    rnd_ready = 1'b0;
    fix_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_pending", bus.out_stream_tvalid, 1);
    tick();
    resetn = 1'b0;
    tick();
    chk("reset_tvalid", bus.out_stream_tvalid, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    resetn = 1'b1;
    fix_ready = 1'b1;
    send_stream(4);
    drain();
    chk("post_reset_words", seen.size(), 3);
    chk("post_reset_sof", seen[0][33], 1);
    chk("post_reset_x0", seen[0][32], 0);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("fc_after_reset", frame_count, 0);
    x0 = n_xfer;
    rnd_ready = 1'b1;
    send_stream(3 * XP * YL);
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    drain();
    chk("words_3frames", n_xfer - x0, 3 * FW);
`ifdef PACKER_FRAME_COUNT_EN
    fc_exp = 3;
`else
    fc_exp = 0;
`endif
    chk("frame_count", frame_count, fc_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
